// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares one BRAM port between requester A (host frame FSM) and requester B
// (local engine). Bursts are granted round-robin on ties, every release costs
// one IDLE turnaround cycle, and a burst is cut at MAX_BURST beats only when
// the other requester is actually waiting.
module bram_port_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          reset_in,

  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          last_a,
  output logic          gnt_a,
  output logic          rvalid_a,
  output logic [DW-1:0] rdata_a,

  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  input  logic          last_b,
  output logic          gnt_b,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_b,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_BURST - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_A = 2'd1;
  localparam logic [1:0] GRANT_B = 2'd2;

  // Index 0 is requester A, index 1 is requester B throughout.
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [CW-1:0] r_beat_cnt;
  logic [CW-1:0] w_beat_cnt_next;
  logic          r_last_owner;
  logic          w_last_owner_next;
  logic [1:0]    r_rvalid;

  logic [1:0]    w_req;
  logic [1:0]    w_we;
  logic [1:0]    w_last;
  logic [1:0]    w_gnt;
  logic [1:0]    w_acc;
  logic [1:0]    w_rd;
  logic          w_own;

  assign w_req  = {req_b, req_a};
  assign w_we   = {we_b, we_a};
  assign w_last = {last_b, last_a};
  assign w_gnt  = {(r_state == GRANT_B), (r_state == GRANT_A)};
  assign w_own  = (r_state == GRANT_B) ? OWNER_B : OWNER_A;

  // Per-requester beat acceptance; reset suppresses any access in its cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign w_acc[gi] = w_req[gi] & w_gnt[gi] & ~reset_in;
      assign w_rd[gi]  = w_acc[gi] & ~w_we[gi];
    end
  endgenerate

  // BRAM port mux: driven only by an accepted beat of the granted requester.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_acc[0]) begin
      mem_en    = 1'b1;
      mem_we    = we_a;
      mem_addr  = addr_a;
      mem_wdata = wdata_a;
    end else if (w_acc[1]) begin
      mem_en    = 1'b1;
      mem_we    = we_b;
      mem_addr  = addr_b;
      mem_wdata = wdata_b;
    end
  end

  // Arbitration and burst bookkeeping for the next cycle.
  always_comb begin
    w_state_next      = r_state;
    w_beat_cnt_next   = r_beat_cnt;
    w_last_owner_next = r_last_owner;
    case (r_state)
      IDLE: begin
        // On a tie A wins unless A owned the port most recently.
        if (w_req[0] && (!w_req[1] || (r_last_owner == OWNER_B))) begin
          w_state_next      = GRANT_A;
          w_last_owner_next = OWNER_A;
          w_beat_cnt_next   = '0;
        end else if (w_req[1]) begin
          w_state_next      = GRANT_B;
          w_last_owner_next = OWNER_B;
          w_beat_cnt_next   = '0;
        end
      end
      GRANT_A, GRANT_B: begin
        if (!w_req[w_own]) begin
          w_state_next = IDLE;
        end else begin
          // A beat is accepted this cycle; the counter wraps at the limit so a
          // lone requester can stream indefinitely under one grant.
          w_beat_cnt_next = (r_beat_cnt == LIMIT) ? '0 : r_beat_cnt + 1'b1;
          if (w_last[w_own]) begin
            w_state_next = IDLE;
          end else if ((r_beat_cnt == LIMIT) && w_req[~w_own]) begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State, burst counter, round-robin memory and read-valid owner tags.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      r_state      <= IDLE;
      r_beat_cnt   <= '0;
      r_last_owner <= OWNER_B;
      r_rvalid     <= 2'b00;
    end else begin
      r_state      <= w_state_next;
      r_beat_cnt   <= w_beat_cnt_next;
      r_last_owner <= w_last_owner_next;
      r_rvalid     <= w_rd;
    end
  end

  assign gnt_a    = w_gnt[0];
  assign gnt_b    = w_gnt[1];
  assign rvalid_a = r_rvalid[0];
  assign rvalid_b = r_rvalid[1];
  assign rdata_a  = mem_rdata;
  assign rdata_b  = mem_rdata;
  assign busy     = (r_state != IDLE);

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 12, BRAM address width; DW, default 8, data width; MAX_BURST, default 16, beats before forced re-arbitration.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 reset_in  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 req_a, req_b  input  1 each  access request from requester A (host frame FSM) and requester B (local engine).
REQ-005 we_a, we_b  input  1 each  beat type: 1 = write, 0 = read.
REQ-006 addr_a, addr_b  input  AW each  beat address.
REQ-007 wdata_a, wdata_b  input  DW each  write data.
REQ-008 last_a, last_b  input  1 each  marks the final beat of a burst.
REQ-009 gnt_a, gnt_b  output  1 each  registered grant; a beat is accepted in each cycle where req_x=1 and gnt_x=1.
REQ-010 rvalid_a, rvalid_b  output  1 each  read data valid for the owning requester.
REQ-011 rdata_a, rdata_b  output  DW each  read data; both driven from mem_rdata.
REQ-012 mem_en, mem_we  output  1 each  BRAM port enable and write enable.
REQ-013 mem_addr  output  AW  BRAM address.
REQ-014 mem_wdata  output  DW  BRAM write data.
REQ-015 mem_rdata  input  DW  BRAM read data, valid 1 cycle after a read beat.
REQ-016 busy  output  1  high in any GRANT state.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, GRANT_A and GRANT_B, with gnt_a=1 only in GRANT_A and gnt_b=1 only in GRANT_B.
REQ-018 IDLE: if only req_a=1, next state is GRANT_A; if only req_b=1, next state is GRANT_B; if neither, stay in IDLE.
REQ-019 IDLE with both requests high: grant the requester other than last_owner.
REQ-020 last_owner SHALL be updated on every entry to a GRANT state; its reset value is B, so A wins the first tie.
REQ-021 mem_en, mem_we, mem_addr and mem_wdata SHALL be combinational from the granted requester: mem_en = req_x & gnt_x and mem_we = mem_en & we_x.
REQ-022 When no requester is granted, all mem_* outputs SHALL be 0.
REQ-023 A read beat in cycle N SHALL produce rvalid_x=1 in cycle N+1 for the same requester, regardless of any state change in between.
REQ-024 rvalid_x SHALL be tracked by a registered owner tag; rdata_a and rdata_b SHALL both equal mem_rdata.
REQ-025 beat_cnt (width clog2(MAX_BURST)+1) SHALL clear on grant entry and increment on each accepted beat.
REQ-026 GRANT_x SHALL return to IDLE on the first of these conditions: (a) an accepted beat with last_x=1; (b) req_x=0; (c) an accepted beat with beat_cnt=MAX_BURST-1 while the other requester's req is 1.
REQ-027 If condition (c) reaches the count limit while the other req=0, beat_cnt SHALL wrap to 0 and the grant SHALL be held.
REQ-028 Each release SHALL spend exactly one IDLE cycle (turnaround) before the next grant, giving a minimum gap of 1 cycle between bursts.
REQ-029 When req_x=1 while not granted, no mem access SHALL occur and requests SHALL NOT be queued.
REQ-030 A requester SHALL keep req, we, addr, wdata and last stable until the cycle its beat is accepted.

Reset
REQ-031 With reset_in=1 at a clock edge, the next state SHALL be: state=IDLE, gnt_a=gnt_b=0, rvalid_a=rvalid_b=0, beat_cnt=0, last_owner=B and busy=0.
REQ-032 During reset, mem_en=0, and the mem_* outputs are therefore 0.
REQ-033 Reset asserted mid-burst SHALL abort the burst and suppress the pending rvalid.
REQ-034 After reset deasserts, the first grant SHALL occur no earlier than 1 cycle later.

Verification
REQ-035 Solo write: req_a=1, we_a=1, addr_a=0x010, wdata_a=0x5A, last_a=1 from IDLE -> gnt_a=1 next cycle; mem_en=mem_we=1, mem_addr=0x010, mem_wdata=0x5A for 1 cycle; then IDLE.
REQ-036 Read latency: B performs a read at addr 0x123 with BRAM holding 0xC3 -> rvalid_b=1 and rdata_b=0xC3 one cycle after the beat; rvalid_a stays 0.
REQ-037 Tie/round-robin: req_a and req_b asserted together from reset, single-beat bursts repeated -> grant order A, B, A, B, with one IDLE cycle between each.
REQ-038 Burst limit: A issues a 40-beat burst without last while B requests from A's beat 5 -> A released after its 16th beat; B granted after 1 IDLE cycle.
REQ-039 No preemption: A issues a 40-beat burst with last on beat 40 and B idle -> single grant for all 40 beats, and beat_cnt wraps twice.
REQ-040 Reset mid-read: reset_in=1 in the cycle of A's read beat -> the next cycle has rvalid_a=0, gnt_a=0, state IDLE, and no mem_en.
